// File: rtl/aes_word_if.sv
// Word-serial front end for a 128-bit AES core: gathers a four-word key and four
// plaintext words, launches the core, then streams the four result words back out.
module aes_word_if #(
    parameter int TIMEOUT = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_we,
    input  logic [1:0]   key_idx,
    input  logic [31:0]  key_word,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         core_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text_in,
    input  logic         core_done,
    input  logic [127:0] core_text_out,
    output logic         busy,
    output logic         err
);
    typedef enum logic [1:0] {COLLECT, LOAD, WAIT, OUT} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    state_t        state, next_state;
    logic [1:0]    wcnt, ocnt;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   key_w [4];
    logic [31:0]   text_w [4];
    logic [127:0]  result;
    logic          abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= COLLECT;
        else      state <= next_state;
    end

    // Handshake outputs depend on state only, so no combinational valid->ready path exists.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_ld    = 1'b0;
        busy       = 1'b1;
        abort      = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && wcnt == 2'd3) next_state = LOAD;
            end
            LOAD: begin
                core_ld    = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    next_state = OUT;
                end else if (wait_cnt == LAST_WAIT) begin
                    next_state = COLLECT;
                    abort      = 1'b1;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready && ocnt == 2'd3) next_state = COLLECT;
            end
        endcase
    end

    // Key and text only change in COLLECT, so they stay frozen through LOAD and WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt     <= '0;
            ocnt     <= '0;
            wait_cnt <= '0;
            result   <= '0;
            err      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                key_w[i]  <= '0;
                text_w[i] <= '0;
            end
        end else begin
            err <= abort;
            case (state)
                COLLECT: begin
                    if (key_we) key_w[key_idx] <= key_word;
                    if (in_valid) begin
                        text_w[wcnt] <= in_data;
                        wcnt         <= wcnt + 2'd1;
                    end
                end
                LOAD: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (core_done) begin
                        result <= core_text_out;
                        ocnt   <= '0;
                    end
                end
                OUT: if (out_ready) ocnt <= ocnt + 2'd1;
            endcase
        end
    end

    assign core_key     = {key_w[0], key_w[1], key_w[2], key_w[3]};
    assign core_text_in = {text_w[0], text_w[1], text_w[2], text_w[3]};
    assign out_last     = (state == OUT) && (ocnt == 2'd3);

    always_comb begin
        out_data = 32'd0;
        if (state == OUT) begin
            case (ocnt)
                2'd0: out_data = result[127:96];
                2'd1: out_data = result[95:64];
                2'd2: out_data = result[63:32];
                2'd3: out_data = result[31:0];
            endcase
        end
    end
endmodule

// File: tb/tb_aes_word_if.sv
// Directed bench for aes_word_if: a queue-based transaction model checked every cycle,
// plus literal expectations for the FIPS-197 vector, backpressure, timeout and reset cases.
module tb_aes_word_if;
    localparam int TIMEOUT = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_we = 1'b0;
    logic [1:0]   key_idx = '0;
    logic [31:0]  key_word = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last;
    logic         core_ld;
    logic [127:0] core_key;
    logic [127:0] core_text_in;
    logic         core_done = 1'b0;
    logic [127:0] core_text_out = '0;
    logic         busy;
    logic         err;

    aes_word_if #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .key_we(key_we), .key_idx(key_idx), .key_word(key_word),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
        .core_done(core_done), .core_text_out(core_text_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ld_count = 0;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Transaction model: words gathered so far, words still owed to the output, and
    // whether a launched block is pending load or awaiting the core.
    logic [31:0]  m_key [4];
    logic [31:0]  m_in_q [$];
    logic [31:0]  m_out_q [$];
    logic [127:0] m_text;
    bit           m_load, m_wait, m_err, m_idle;
    int           m_wait_cycles;

    function automatic bit modelIdle();
        return !(m_load || m_wait || m_out_q.size() > 0);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) m_key[i] = '0;
        m_in_q.delete();
        m_out_q.delete();
        m_text = '0;
        m_load = 0;
        m_wait = 0;
        m_err = 0;
        m_wait_cycles = 0;
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                modelReset();
            end else begin
                m_idle = modelIdle();
                m_err = 0;
                if (m_idle) begin
                    if (key_we) m_key[key_idx] = key_word;
                    if (in_valid) begin
                        m_in_q.push_back(in_data);
                        if (m_in_q.size() == 4) begin
                            m_text = {m_in_q[0], m_in_q[1], m_in_q[2], m_in_q[3]};
                            m_in_q.delete();
                            m_load = 1;
                        end
                    end
                end else if (m_load) begin
                    m_load = 0;
                    m_wait = 1;
                    m_wait_cycles = 0;
                end else if (m_wait) begin
                    m_wait_cycles++;
                    if (core_done) begin
                        m_wait = 0;
                        for (int i = 3; i >= 0; i--) m_out_q.push_back(core_text_out[i*32 +: 32]);
                    end else if (m_wait_cycles == TIMEOUT) begin
                        m_wait = 0;
                        m_err = 1;
                    end
                end else if (out_ready) begin
                    void'(m_out_q.pop_front());
                end
            end
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (core_ld === 1'b1) ld_count++;
            checkOutput("in_ready", 128'(in_ready), 128'(modelIdle()));
            checkOutput("busy", 128'(busy), 128'(!modelIdle()));
            checkOutput("core_ld", 128'(core_ld), 128'(m_load));
            checkOutput("err", 128'(err), 128'(m_err));
            checkOutput("out_valid", 128'(out_valid), 128'(m_out_q.size() > 0));
            if (m_out_q.size() > 0) begin
                checkOutput("out_data", 128'(out_data), 128'(m_out_q[0]));
                checkOutput("out_last", 128'(out_last), 128'(m_out_q.size() == 1));
            end else begin
                checkOutput("out_last_idle", 128'(out_last), 128'(0));
            end
            if (m_load || m_wait) begin
                checkOutput("core_key", core_key, {m_key[0], m_key[1], m_key[2], m_key[3]});
                checkOutput("core_text_in", core_text_in, m_text);
            end
            if (!rst) checkOutput("out_data_rst", 128'(out_data), 128'(0));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] id,
                                 input logic kwe, input logic [1:0] kidx, input logic [31:0] kw,
                                 input logic ordy, input logic cd, input logic [127:0] cto);
        in_valid = iv;
        in_data = id;
        key_we = kwe;
        key_idx = kidx;
        key_word = kw;
        out_ready = ordy;
        core_done = cd;
        core_text_out = cto;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 0, 0, 128'h0);
    endtask

    task automatic writeKey(input logic [127:0] k);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 32'h0, 1, 2'(i), k[(3-i)*32 +: 32], 0, 0, 128'h0);
    endtask

    // Four input beats; the last may carry a key write. Returns in the LOAD cycle.
    task automatic sendBlock(input logic [127:0] pt, input logic kwe, input logic [1:0] kidx, input logic [31:0] kw);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, pt[(3-i)*32 +: 32], (i == 3) ? kwe : 1'b0, kidx, kw, 0, 0, 128'h0);
    endtask

    // From LOAD: one WAIT cycle, then core_done, then drain checking each word literally.
    task automatic finishBlock(input logic [127:0] ct, input int drain);
        idle(2);
        applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 0, 1, ct);
        for (int i = 0; i < drain; i++) begin
            checkOutput("drain_valid", 128'(out_valid), 128'(1));
            checkOutput("drain_word", 128'(out_data), 128'(ct[(3-i)*32 +: 32]));
            checkOutput("drain_last", 128'(out_last), 128'(i == 3));
            applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 1, 0, 128'h0);
        end
    endtask

    int n;
    int ld_before;

    initial begin
        // Reset values
        idle(2);
        checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_core_key", core_key, 128'h0);
        rst = 1'b1;
        idle(1);

        // FIPS-197 vector
        writeKey(FIPS_KEY);
        ld_before = ld_count;
        sendBlock(FIPS_PT, 0, 2'd0, 32'h0);
        checkOutput("fips_ld", 128'(core_ld), 128'(1));
        checkOutput("fips_text", core_text_in, 128'h00112233445566778899aabbccddeeff);
        checkOutput("fips_key", core_key, 128'h000102030405060708090a0b0c0d0e0f);
        finishBlock(FIPS_CT, 0);
        checkOutput("fips_w0", 128'(out_data), 128'(32'h69c4e0d8));
        applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 1, 0, 128'h0);
        checkOutput("fips_w1", 128'(out_data), 128'(32'h6a7b0430));
        applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 1, 0, 128'h0);
        checkOutput("fips_w2", 128'(out_data), 128'(32'hd8cdb780));
        applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 1, 0, 128'h0);
        checkOutput("fips_w3", 128'(out_data), 128'(32'h70b4c55a));
        checkOutput("fips_last", 128'(out_last), 128'(1));
        applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 1, 0, 128'h0);
        checkOutput("fips_ld_pulses", 128'(ld_count - ld_before), 128'(1));
        checkOutput("fips_done_ready", 128'(in_ready), 128'(1));

        // Output backpressure with input offered
        sendBlock(128'h11111111222222223333333344444444, 0, 2'd0, 32'h0);
        finishBlock(128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold", 128'(out_data), 128'(32'ha0a1a2a3));
            checkOutput("bp_no_input", 128'(in_ready), 128'(0));
            applyStimulus(1, 32'hbad0bad0, 0, 2'd0, 32'h0, 0, 0, 128'h0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 1, 0, 128'h0);

        // Timeout: no core_done
        sendBlock(128'h0badc0de0badc0de0badc0de0badc0de, 0, 2'd0, 32'h0);
        idle(1);
        n = 0;
        while (err !== 1'b1 && n < 2 * TIMEOUT) begin
            idle(1);
            n++;
        end
        checkOutput("timeout_cycles", 128'(n), 128'(20));
        idle(1);
        checkOutput("timeout_err_once", 128'(err), 128'(0));
        checkOutput("timeout_in_ready", 128'(in_ready), 128'(1));
        checkOutput("timeout_no_out", 128'(out_valid), 128'(0));

        // core_done on the last allowed WAIT cycle wins; key write while busy is dropped
        sendBlock(128'h01010101020202020303030304040404, 0, 2'd0, 32'h0);
        idle(1);
        applyStimulus(0, 32'h0, 1, 2'd0, 32'hdeadbeef, 0, 0, 128'h0);
        idle(TIMEOUT - 2);
        applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 0, 1, 128'h5555aaaa5555aaaa5555aaaa5555aaaa);
        checkOutput("race_out_valid", 128'(out_valid), 128'(1));
        checkOutput("race_no_err", 128'(err), 128'(0));
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 1, 0, 128'h0);
        sendBlock(128'h0, 0, 2'd0, 32'h0);
        checkOutput("busy_key_dropped", core_key, 128'h000102030405060708090a0b0c0d0e0f);
        finishBlock(128'h1, 4);

        // Key write on the fourth beat lands in this block
        sendBlock(128'h2, 1, 2'd3, 32'hcafef00d);
        checkOutput("key_on_beat4", core_key, 128'h000102030405060708090a0bcafef00d);
        finishBlock(128'h3, 4);

        // Reset during OUT after two words
        sendBlock(128'h4, 0, 2'd0, 32'h0);
        finishBlock(128'hf0f0f0f0e1e1e1e1d2d2d2d2c3c3c3c3, 2);
        rst = 1'b0;
        #1;
        checkOutput("rst_out_valid_now", 128'(out_valid), 128'(0));
        checkOutput("rst_key_cleared", core_key, 128'h0);
        idle(1);
        rst = 1'b1;
        idle(1);
        writeKey(FIPS_KEY);
        sendBlock(FIPS_PT, 0, 2'd0, 32'h0);
        finishBlock(FIPS_CT, 0);
        checkOutput("post_rst_word0", 128'(out_data), 128'(32'h69c4e0d8));
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 1, 0, 128'h0);

        // Stray core_done in COLLECT, mid-block
        applyStimulus(1, 32'haaaa0000, 0, 2'd0, 32'h0, 0, 0, 128'h0);
        applyStimulus(1, 32'haaaa1111, 0, 2'd0, 32'h0, 0, 0, 128'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h0, 0, 2'd0, 32'h0, 1, 1, 128'hffffffffffffffffffffffffffffffff);
            checkOutput("stray_busy", 128'(busy), 128'(0));
            checkOutput("stray_out_valid", 128'(out_valid), 128'(0));
        end
        applyStimulus(1, 32'haaaa2222, 0, 2'd0, 32'h0, 0, 0, 128'h0);
        applyStimulus(1, 32'haaaa3333, 0, 2'd0, 32'h0, 0, 0, 128'h0);
        checkOutput("stray_text", core_text_in, 128'haaaa0000aaaa1111aaaa2222aaaa3333);
        finishBlock(128'h9, 4);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
